// File: rtl/key_event_ctrl.sv
// key_event_ctrl: front-panel key scanner.
//   Synchronizes raw active-low key levels, debounces them on a prescaled
//   sample strobe, and queues one press/release event per accepted level
//   change into an 8-entry first-word-fall-through event FIFO.
//
// Ports
//   clk         single clock for all logic
//   reset_n     asynchronous active-low reset
//   keys_n      raw key levels, 0 = pressed (asynchronous)
//   key_state   debounced level per key, 1 = pressed
//   any_pressed OR of key_state
//   evt_valid   head of event FIFO is valid
//   evt_ready   consumer pop request
//   evt_data    head event: bit7 = 1 press / 0 release, bits3:0 = key index
//   evt_count   FIFO occupancy 0..8
//   ovf         sticky flag, an event was dropped because the FIFO was full
//   ovf_clr     synchronous clear of ovf
//
// Handshake: an event is popped on any rising edge where evt_valid and
// evt_ready are both 1. evt_data is stable while evt_valid = 1 and no pop
// happens; evt_ready while evt_valid = 0 is ignored.
module key_event_ctrl #(
  parameter int N_KEYS      = 13,
  parameter int DIV         = 50000,
  parameter int DEB_SAMPLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] keys_n,
  output logic [N_KEYS-1:0] key_state,
  output logic              any_pressed,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [7:0]        evt_data,
  output logic [3:0]        evt_count,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int PW = $clog2(DIV);

  // Input synchronizer (idle level is 1 = released)
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] pressed;
  assign pressed = ~sync2_q;

  // Sample strobe prescaler
  logic [PW-1:0] presc_q, presc_d;
  logic          strobe;
  assign strobe  = (presc_q == PW'(DIV - 1));
  assign presc_d = strobe ? '0 : presc_q + PW'(1);

  // Debounce state
  logic [3:0]        deb_cnt_q [N_KEYS];
  logic [3:0]        deb_cnt_d [N_KEYS];
  logic [N_KEYS-1:0] key_state_q, key_state_d;
  logic [N_KEYS-1:0] pend_q, pend_d, pend_set, pend_clr;

  // Event selection
  logic       sel_vld;
  logic [3:0] sel_idx;
  logic       sel_state;
  logic [7:0] push_data;

  // FIFO: 8-entry storage feeding a registered head. A pushed event lands in
  // storage first and moves to the head register on the following edge, so a
  // lone change reaches evt_valid two edges after the strobe that accepted it.
  logic [7:0] mem_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] mem_cnt_q, mem_cnt_d;
  logic       out_valid_q;
  logic [7:0] out_data_q;
  logic [3:0] evt_count_q, evt_count_d;
  logic       ovf_q, ovf_d;
  logic       full, pop, push_ok, drop, load;

  always_comb begin
    key_state_d = key_state_q;
    pend_set    = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (strobe) begin
        if (pressed[i] != key_state_q[i]) begin
          // The sample that would bring the count to DEB_SAMPLES accepts the change.
          if (deb_cnt_q[i] == 4'(DEB_SAMPLES - 1)) begin
            key_state_d[i] = ~key_state_q[i];
            deb_cnt_d[i]   = '0;
            pend_set[i]    = 1'b1;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
          end
        end else begin
          deb_cnt_d[i] = '0;
        end
      end
    end
  end

  // Lowest-index pending key wins; descending scan lets the lowest overwrite.
  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = '0;
    sel_state = 1'b0;
    pend_clr  = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_vld     = 1'b1;
        sel_idx     = 4'(i);
        sel_state   = key_state_q[i];
        pend_clr    = '0;
        pend_clr[i] = 1'b1;
      end
    end
  end

  assign pend_d    = (pend_q & ~pend_clr) | pend_set;
  assign push_data = {sel_state, 3'b000, sel_idx};

  assign full    = (evt_count_q == 4'd8);
  assign pop     = out_valid_q & evt_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push_ok = sel_vld & (~full | pop);
  assign drop    = sel_vld & full & ~pop;
  assign load    = (~out_valid_q | pop) & (mem_cnt_q != 4'd0);

  assign mem_cnt_d   = mem_cnt_q + 4'(push_ok) - 4'(load);
  assign evt_count_d = evt_count_q + 4'(push_ok) - 4'(pop);

  // A drop outranks a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      presc_q     <= '0;
      key_state_q <= '0;
      pend_q      <= '0;
      for (int i = 0; i < N_KEYS; i++) deb_cnt_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      evt_count_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= keys_n;
      sync2_q     <= sync1_q;
      presc_q     <= presc_d;
      key_state_q <= key_state_d;
      pend_q      <= pend_d;
      for (int i = 0; i < N_KEYS; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      if (push_ok) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (load) begin
        rd_ptr_q    <= rd_ptr_q + 3'd1;
        out_valid_q <= 1'b1;
        out_data_q  <= mem_q[rd_ptr_q];
      end else if (pop) begin
        out_valid_q <= 1'b0;
      end
      mem_cnt_q   <= mem_cnt_d;
      evt_count_q <= evt_count_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage array needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign key_state   = key_state_q;
  assign any_pressed = |key_state_q;
  assign evt_valid   = out_valid_q;
  assign evt_data    = out_data_q;
  assign evt_count   = evt_count_q;
  assign ovf         = ovf_q;

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 SHALL have parameter N_KEYS, default 13, number of front-panel keys (max 16).
REQ-002 SHALL have parameter DIV, default 50000, clk cycles per debounce sample strobe (DIV >= 16).
REQ-003 SHALL have parameter DEB_SAMPLES, default 4, consecutive differing samples needed to accept a level change (2..15).
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port keys_n, input, N_KEYS, raw asynchronous key levels, 0 = pressed.
REQ-007 SHALL have port key_state, output, N_KEYS, debounced level per key, 1 = pressed.
REQ-008 SHALL have port any_pressed, output, 1, OR of key_state.
REQ-009 SHALL have port evt_valid, output, 1, event FIFO non-empty.
REQ-010 SHALL have port evt_ready, input, 1, consumer pop request.
REQ-011 SHALL have port evt_data, output, 8, head event: bit7 = 1 press / 0 release, bits6:4 = 0, bits3:0 = key index.
REQ-012 SHALL have port evt_count, output, 4, FIFO occupancy 0..8.
REQ-013 SHALL have port ovf, output, 1, sticky event-dropped flag.
REQ-014 SHALL have port ovf_clr, input, 1, synchronous clear of ovf.

Function
REQ-015 SHALL pass each keys_n bit through a 2-flop synchronizer before any other use.
REQ-016 SHALL run a prescaler counting 0..DIV-1 and wrapping, with a strobe asserted for one cycle when the count equals DIV-1.
REQ-017 SHALL keep a 4-bit per-key counter: on a strobe, increment it if the synchronized pressed level differs from key_state, otherwise clear it; off-strobe it holds.
REQ-018 SHALL toggle key_state, clear the counter, and set that key's pending bit on the strobe edge at which the counter would reach DEB_SAMPLES.
REQ-019 SHALL evaluate each cycle the lowest-index set pending bit, clear it, and push {key_state[i], 3'b000, i[3:0]} into the FIFO on the same edge.
REQ-020 SHALL drop a push when the FIFO holds 8 entries and no pop occurs that cycle, still clear the pending bit, and set ovf.
REQ-021 SHALL accept a push and a pop in the same cycle when full, leaving evt_count at 8.
REQ-022 SHALL implement the FIFO as an 8-entry first-word-fall-through queue, with evt_data valid whenever evt_valid = 1 and held stable until popped.
REQ-023 SHALL pop on evt_valid & evt_ready; evt_ready while empty has no effect.
REQ-024 SHALL give ovf_clr priority below a same-cycle drop, so ovf remains 1.
REQ-025 SHALL update key_state on the strobe edge; the event for a lone change SHALL appear on evt_valid exactly 2 clk edges later when the FIFO is empty.
REQ-026 SHALL, for simultaneous changes on one strobe, queue events in ascending key index, one per cycle.

Reset
REQ-027 SHALL reset asynchronously on reset_n = 0: synchronizer flops to 1, prescaler, debounce counters, pending bits, FIFO pointers, ovf, key_state, any_pressed, evt_valid and evt_count all to 0; evt_data to 0.
REQ-028 SHALL discard all queued events and in-progress debounce state on a mid-operation reset; a key held across reset SHALL produce a fresh press event after debounce.

Verification (DIV=16, DEB_SAMPLES=4)
REQ-029 SHALL test: key 5 held low for 6 strobes -> key_state[5] = 1 on the 4th strobe, evt_data = 0x85 valid 2 edges later, evt_count = 1.
REQ-030 SHALL test: key 2 glitches low for 3 strobes then high -> no event, key_state stays 0, counter cleared.
REQ-031 SHALL test: keys 0, 7 and 12 pressed in the same cycle -> events 0x80, 0x87, 0x8C on consecutive cycles.
REQ-032 SHALL test: evt_ready = 0, 9 distinct press events -> evt_count = 8, ovf = 1, 9th event lost; with ovf_clr pulsed, ovf = 0.
REQ-033 SHALL test: FIFO full, push and pop in the same cycle -> count stays 8, ovf stays 0, order preserved.
REQ-034 SHALL test: reset_n pulsed low with 3 events queued and key 1 held -> all outputs 0 immediately, then 0x81 after 4 strobes.
